cdr_phase_controller: RTL and testbench

Bang-bang CDR loop controller that sequences the 8-bit phase word feeding the phase interpolator. It accumulates early/late votes from the phase detector and steps the phase up or down by one code when the accumulator reaches a threshold. A two-mode FSM runs a fast acquisition threshold until dithering indicates lock, then a slow tracking threshold. It sits between the phase detector and the interpolator, replacing the free-running phase source.

---
 rtl/cdr_pkg.sv | 22 ++
 rtl/phase_vote_accumulator.sv | 45 ++++
 rtl/cdr_phase_controller.sv | 147 ++++++++++++++
 tb/tb_cdr_phase_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cdr_pkg.sv
// Shared encodings and default parameters for the bang-bang CDR phase controller.
package cdr_pkg;

  typedef enum logic {
    CDR_ACQ = 1'b0,
    CDR_TRK = 1'b1
  } cdr_mode_e;

  typedef enum logic [1:0] {
    VOTE_NULL = 2'd0,
    VOTE_UP   = 2'd1,
    VOTE_DN   = 2'd2
  } cdr_vote_e;

  localparam int CDR_PHASE_W_DEF    = 8;
  localparam int CDR_ACC_W_DEF      = 6;
  localparam int CDR_ACQ_THRESH_DEF = 4;
  localparam int CDR_TRK_THRESH_DEF = 16;
  localparam int CDR_LOCK_REV_DEF   = 4;
  localparam int CDR_LOSS_RUN_DEF   = 8;

endpackage

// File: rtl/phase_vote_accumulator.sv
// Signed early/late vote accumulator; flags a step in the cycle the vote hits +/-thr.
// Step flags are combinational from the current vote; the accumulator clears on a step or i_clr.
module phase_vote_accumulator
  import cdr_pkg::*;
#(
  parameter int ACC_W = CDR_ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  cdr_vote_e        i_vote,
  input  logic [ACC_W-1:0] i_thr,
  input  logic             i_clr,
  output logic             o_step_up,
  output logic             o_step_dn
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_delta;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W-1:0] w_thr_s;

  always_comb begin
    w_delta = '0;
    case (i_vote)
      VOTE_UP: w_delta = ACC_W'(1);
      VOTE_DN: w_delta = '1;
      default: w_delta = '0;
    endcase
    w_thr_s    = $signed(i_thr);
    w_acc_next = r_acc + w_delta;
    o_step_up  = (i_vote == VOTE_UP) && (w_acc_next == w_thr_s);
    o_step_dn  = (i_vote == VOTE_DN) && (w_acc_next == -w_thr_s);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_clr || o_step_up || o_step_dn) begin
      r_acc <= '0;
    end else if (i_vote != VOTE_NULL) begin
      r_acc <= w_acc_next;
    end
  end

endmodule

// File: rtl/cdr_phase_controller.sv
// Bang-bang CDR controller driving the interpolator phase word; ACQ/TRK lock FSM under CDR_LOCK_DET_EN.
// Phase updates on the edge of the threshold-crossing vote; freeze discards votes and holds all state.
module cdr_phase_controller
  import cdr_pkg::*;
#(
  parameter int PHASE_W    = CDR_PHASE_W_DEF,
  parameter int ACC_W      = CDR_ACC_W_DEF,
  parameter int ACQ_THRESH = CDR_ACQ_THRESH_DEF,
  parameter int TRK_THRESH = CDR_TRK_THRESH_DEF,
  parameter int LOCK_REV   = CDR_LOCK_REV_DEF,
  parameter int LOSS_RUN   = CDR_LOSS_RUN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vote_valid,
  input  logic               early,
  input  logic               late,
  input  logic               freeze,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_step,
  output logic               phase_dir,
  output logic               locked,
  output logic               mode
);

  cdr_vote_e          w_vote;
  logic               w_step_up;
  logic               w_step_dn;
  logic               w_step;
  logic [ACC_W-1:0]   w_thr;
  logic               w_acc_clr;
  logic [PHASE_W-1:0] r_phase;
  logic               r_phase_step;
  logic               r_phase_dir;

  always_comb begin
    w_vote = VOTE_NULL;
    if (vote_valid && !freeze) begin
      if (early && !late)      w_vote = VOTE_UP;
      else if (late && !early) w_vote = VOTE_DN;
    end
  end

  phase_vote_accumulator #(.ACC_W(ACC_W)) u_acc (
    .clk       (clk),
    .rst       (rst),
    .i_vote    (w_vote),
    .i_thr     (w_thr),
    .i_clr     (w_acc_clr),
    .o_step_up (w_step_up),
    .o_step_dn (w_step_dn)
  );

  assign w_step = w_step_up | w_step_dn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase      <= '0;
      r_phase_step <= 1'b0;
      r_phase_dir  <= 1'b0;
    end else begin
      r_phase_step <= w_step;
      if (w_step_up) begin
        r_phase     <= r_phase + PHASE_W'(1);
        r_phase_dir <= 1'b1;
      end else if (w_step_dn) begin
        r_phase     <= r_phase - PHASE_W'(1);
        r_phase_dir <= 1'b0;
      end
    end
  end

  assign phase      = r_phase;
  assign phase_step = r_phase_step;
  assign phase_dir  = r_phase_dir;

`ifdef CDR_LOCK_DET_EN
  localparam int REV_W = $clog2(LOCK_REV + 1);
  localparam int RUN_W = $clog2(LOSS_RUN + 1);

  cdr_mode_e        r_mode;
  cdr_mode_e        w_mode_nxt;
  logic [REV_W-1:0] r_rev_cnt;
  logic [REV_W-1:0] w_rev_nxt;
  logic [RUN_W-1:0] r_run_cnt;
  logic [RUN_W-1:0] w_run_nxt;
  logic             r_hist_vld;
  logic             w_same;

  // With no step history yet, the first step is treated as same-direction.
  always_comb begin
    w_same     = !r_hist_vld || (w_step_up == r_phase_dir);
    w_rev_nxt  = r_rev_cnt;
    w_run_nxt  = r_run_cnt;
    w_mode_nxt = r_mode;
    if (w_step) begin
      if (w_same) begin
        w_rev_nxt = '0;
        w_run_nxt = (r_run_cnt == RUN_W'(LOSS_RUN)) ? r_run_cnt : r_run_cnt + RUN_W'(1);
      end else begin
        w_run_nxt = '0;
        w_rev_nxt = (r_rev_cnt == REV_W'(LOCK_REV)) ? r_rev_cnt : r_rev_cnt + REV_W'(1);
      end
    end
    case (r_mode)
      CDR_ACQ: if (w_rev_nxt == REV_W'(LOCK_REV)) w_mode_nxt = CDR_TRK;
      CDR_TRK: if (w_run_nxt == RUN_W'(LOSS_RUN)) w_mode_nxt = CDR_ACQ;
      default: w_mode_nxt = CDR_ACQ;
    endcase
    if (w_mode_nxt != r_mode) begin
      w_rev_nxt = '0;
      w_run_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_mode <= CDR_ACQ;
    else      r_mode <= w_mode_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rev_cnt  <= '0;
      r_run_cnt  <= '0;
      r_hist_vld <= 1'b0;
    end else begin
      r_rev_cnt <= w_rev_nxt;
      r_run_cnt <= w_run_nxt;
      if (w_step) r_hist_vld <= 1'b1;
    end
  end

  assign w_acc_clr = (w_mode_nxt != r_mode);
  assign w_thr     = (r_mode == CDR_TRK) ? ACC_W'(TRK_THRESH) : ACC_W'(ACQ_THRESH);
  assign mode      = (r_mode == CDR_TRK);
  assign locked    = (r_mode == CDR_TRK);
`else
  logic [31:0] w_unused_cfg;

  assign w_unused_cfg = ACQ_THRESH ^ LOCK_REV ^ LOSS_RUN;
  assign w_acc_clr    = 1'b0;
  assign w_thr        = ACC_W'(TRK_THRESH);
  assign mode         = 1'b0;
  assign locked       = 1'b0;
`endif

endmodule

// File: tb/tb_cdr_phase_controller.sv
// Directed bench for cdr_phase_controller; expectations follow the CDR_LOCK_DET_EN build setting.
module tb_cdr_phase_controller;

`ifdef CDR_LOCK_DET_EN
  localparam int THR0 = 4;
`else
  localparam int THR0 = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vote_valid = 1'b0;
  logic       early = 1'b0;
  logic       late = 1'b0;
  logic       freeze = 1'b0;
  logic [7:0] phase;
  logic       phase_step;
  logic       phase_dir;
  logic       locked;
  logic       mode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cdr_phase_controller dut (
    .clk        (clk),
    .rst        (rst),
    .vote_valid (vote_valid),
    .early      (early),
    .late       (late),
    .freeze     (freeze),
    .phase      (phase),
    .phase_step (phase_step),
    .phase_dir  (phase_dir),
    .locked     (locked),
    .mode       (mode)
  );

  task automatic drive(input logic v, input logic e, input logic l, input logic f);
    vote_valid = v; early = e; late = l; freeze = f;
    @(posedge clk);
    #1;
  endtask

  task automatic votes(input int n, input logic e, input logic l, output int steps);
    steps = 0;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, e, l, 1'b0);
      if (phase_step) steps++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (phase !== 8'd0)    begin bad++; $display("FAIL reset_phase got=%0d exp=0", phase); end
    total++; if (phase_step !== 1'b0) begin bad++; $display("FAIL reset_step got=%b exp=0", phase_step); end
    total++; if (phase_dir !== 1'b0)  begin bad++; $display("FAIL reset_dir got=%b exp=0", phase_dir); end
    total++; if (mode !== 1'b0)       begin bad++; $display("FAIL reset_mode got=%b exp=0", mode); end
    total++; if (locked !== 1'b0)     begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    rst = 1'b1;
  endtask

  task automatic test_up_down_step();
    int s;
    votes(THR0 - 1, 1'b1, 1'b0, s);
    total++; if (s !== 0 || phase !== 8'd0) begin bad++; $display("FAIL pre_up steps=%0d phase=%0d exp 0/0", s, phase); end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (phase !== 8'd1)      begin bad++; $display("FAIL up_phase got=%0d exp=1", phase); end
    total++; if (phase_step !== 1'b1) begin bad++; $display("FAIL up_step got=%b exp=1", phase_step); end
    total++; if (phase_dir !== 1'b1)  begin bad++; $display("FAIL up_dir got=%b exp=1", phase_dir); end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (phase_step !== 1'b0 || phase !== 8'd1) begin bad++; $display("FAIL up_pulse step=%b phase=%0d exp 0/1", phase_step, phase); end
    votes(THR0 - 1, 1'b0, 1'b1, s);
    total++; if (s !== 0 || phase !== 8'd1) begin bad++; $display("FAIL acc_clear steps=%0d phase=%0d exp 0/1", s, phase); end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (phase !== 8'd0 || phase_dir !== 1'b0 || phase_step !== 1'b1) begin
      bad++; $display("FAIL dn_step phase=%0d dir=%b step=%b exp 0/0/1", phase, phase_dir, phase_step);
    end
  endtask

  task automatic test_wrap();
    int s;
    votes(THR0, 1'b0, 1'b1, s);
    total++; if (phase !== 8'd255 || phase_dir !== 1'b0 || s !== 1) begin
      bad++; $display("FAIL wrap_dn phase=%0d dir=%b steps=%0d exp 255/0/1", phase, phase_dir, s);
    end
    votes(THR0, 1'b1, 1'b0, s);
    total++; if (phase !== 8'd0 || phase_dir !== 1'b1 || s !== 1) begin
      bad++; $display("FAIL wrap_up phase=%0d dir=%b steps=%0d exp 0/1/1", phase, phase_dir, s);
    end
  endtask

  task automatic test_null_freeze();
    int s;
    int n;
    n = 0;
    votes(3, 1'b1, 1'b0, s);
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b1, 1'b1, 1'b0); if (phase_step) n++; end
    for (int i = 0; i < THR0; i++) begin drive(1'b1, 1'b1, 1'b0, 1'b1); if (phase_step) n++; end
    for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b1, 1'b0, 1'b0); if (phase_step) n++; end
    for (int i = 0; i < THR0; i++) begin drive(1'b1, 1'b0, 1'b1, 1'b1); if (phase_step) n++; end
    total++; if (n !== 0 || phase !== 8'd0 || mode !== 1'b0) begin
      bad++; $display("FAIL null_freeze steps=%0d phase=%0d mode=%b exp 0/0/0", n, phase, mode);
    end
    votes(THR0 - 4, 1'b1, 1'b0, s);
    total++; if (s !== 0 || phase !== 8'd0) begin bad++; $display("FAIL acc_held steps=%0d phase=%0d exp 0/0", s, phase); end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    total++; if (phase_step !== 1'b0 || phase !== 8'd0) begin bad++; $display("FAIL freeze_cross step=%b phase=%0d exp 0/0", phase_step, phase); end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (phase_step !== 1'b1 || phase !== 8'd1) begin bad++; $display("FAIL after_freeze step=%b phase=%0d exp 1/1", phase_step, phase); end
  endtask

  task automatic test_mode();
    int s;
    logic exp_mode;
    do_reset();
    for (int b = 0; b < 5; b++) begin
      votes(THR0, (b % 2) == 0, (b % 2) == 1, s);
`ifdef CDR_LOCK_DET_EN
      exp_mode = (b == 4);
`else
      exp_mode = 1'b0;
`endif
      total++; if (s !== 1 || phase_step !== 1'b1 || mode !== exp_mode || locked !== exp_mode) begin
        bad++; $display("FAIL alt_blk%0d steps=%0d step=%b mode=%b locked=%b exp 1/1/%b/%b", b, s, phase_step, mode, locked, exp_mode, exp_mode);
      end
    end
`ifdef CDR_LOCK_DET_EN
    votes(THR0, 1'b1, 1'b0, s);
    total++; if (s !== 0 || phase !== 8'd1) begin bad++; $display("FAIL trk_thr steps=%0d phase=%0d exp 0/1", s, phase); end
    votes(16 - THR0, 1'b1, 1'b0, s);
`else
    votes(16, 1'b1, 1'b0, s);
`endif
    total++; if (s !== 1 || phase_step !== 1'b1 || phase !== 8'd2) begin
      bad++; $display("FAIL run_blk0 steps=%0d step=%b phase=%0d exp 1/1/2", s, phase_step, phase);
    end
    for (int k = 1; k < 8; k++) begin
      votes(16, 1'b1, 1'b0, s);
`ifdef CDR_LOCK_DET_EN
      exp_mode = (k < 7);
`else
      exp_mode = 1'b0;
`endif
      total++; if (s !== 1 || phase_step !== 1'b1 || mode !== exp_mode || locked !== exp_mode) begin
        bad++; $display("FAIL run_blk%0d steps=%0d step=%b mode=%b locked=%b exp 1/1/%b/%b", k, s, phase_step, mode, locked, exp_mode, exp_mode);
      end
    end
    total++; if (phase !== 8'd9) begin bad++; $display("FAIL run_phase got=%0d exp=9", phase); end
    votes(THR0 - 1, 1'b1, 1'b0, s);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (s !== 0 || phase_step !== 1'b1 || phase !== 8'd10) begin
      bad++; $display("FAIL post_run steps=%0d step=%b phase=%0d exp 0/1/10", s, phase_step, phase);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    do_reset();
`ifdef CDR_LOCK_DET_EN
    for (int b = 0; b < 5; b++) votes(THR0, (b % 2) == 0, (b % 2) == 1, s);
    total++; if (mode !== 1'b1) begin bad++; $display("FAIL mid_pre_mode got=%b exp=1", mode); end
`else
    votes(THR0, 1'b1, 1'b0, s);
`endif
    votes(3, 1'b1, 1'b0, s);
    total++; if (phase !== 8'd1 || phase_dir !== 1'b1) begin bad++; $display("FAIL mid_pre phase=%0d dir=%b exp 1/1", phase, phase_dir); end
    #2 rst = 1'b0;
    #1;
    total++; if (phase !== 8'd0 || mode !== 1'b0 || locked !== 1'b0 || phase_dir !== 1'b0 || phase_step !== 1'b0) begin
      bad++; $display("FAIL mid_reset phase=%0d mode=%b locked=%b dir=%b step=%b exp all 0", phase, mode, locked, phase_dir, phase_step);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    votes(THR0, 1'b1, 1'b0, s);
    total++; if (phase !== 8'd1 || s !== 1 || phase_step !== 1'b1) begin
      bad++; $display("FAIL mid_release phase=%0d steps=%0d step=%b exp 1/1/1", phase, s, phase_step);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_up_down_step();
    test_wrap();
    test_null_freeze();
    test_mode();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
